counter_hex_display: RTL

//   Reader end of the 24-bit counter bus: takes the count produced by the
//   up/down counter and shows it as 6 hex digits on a multiplexed 7-segment

---
 rtl/counter_hex_display.sv | 125 ++++++++++++
 1 files changed

// File: rtl/counter_hex_display.sv
// Multiplexed 6-digit hex display driver: latches a snapshot of value_in once per
// frame and scans it onto shared segment/anode pins. Optional DISP_BLANK_LEADING_ZERO_EN.
module counter_hex_display #(
    parameter int WIDTH          = 24,
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  value_in,
    input  logic              hold,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{SEG_ACTIVE_LOW != 0}};

    logic [PW-1:0]     prescale_q, prescale_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  snapshot_q, snapshot_d;
    logic              frameTick_q, frameTick_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic              terminal;
    logic              frameEnd;
    logic [3:0]        nibble;
    logic [DIGITS-1:0] anOneHot;
    logic              blank;
    logic [6:0]        segActive;
`ifdef DISP_BLANK_LEADING_ZERO_EN
    logic              zeroAbove;
`endif

    function automatic logic [6:0] hexDecode(input logic [3:0] n);
        case (n)
            4'h0: hexDecode = 7'b0111111;
            4'h1: hexDecode = 7'b0000110;
            4'h2: hexDecode = 7'b1011011;
            4'h3: hexDecode = 7'b1001111;
            4'h4: hexDecode = 7'b1100110;
            4'h5: hexDecode = 7'b1101101;
            4'h6: hexDecode = 7'b1111101;
            4'h7: hexDecode = 7'b0000111;
            4'h8: hexDecode = 7'b1111111;
            4'h9: hexDecode = 7'b1101111;
            4'hA: hexDecode = 7'b1110111;
            4'hB: hexDecode = 7'b1111100;
            4'hC: hexDecode = 7'b0111001;
            4'hD: hexDecode = 7'b1011110;
            4'hE: hexDecode = 7'b1111001;
            default: hexDecode = 7'b1110001;
        endcase
    endfunction

    always_comb begin
        terminal    = (prescale_q == PRE_LAST);
        frameEnd    = terminal && (idx_q == IDX_LAST);
        prescale_d  = terminal ? '0 : prescale_q + 1'b1;
        idx_d       = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        snapshot_d  = snapshot_q;
        if (frameEnd && !hold) begin
            snapshot_d = value_in;
        end
        frameTick_d = frameEnd;

        nibble   = '0;
        anOneHot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nibble      = snapshot_q[4*k +: 4];
                anOneHot[k] = 1'b1;
            end
        end

        blank = 1'b0;
`ifdef DISP_BLANK_LEADING_ZERO_EN
        // Walk from the top digit down so zeroAbove covers nibbles k..DIGITS-1.
        zeroAbove = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zeroAbove = zeroAbove && (snapshot_q[4*k +: 4] == 4'h0);
            if ((k != 0) && (idx_q == IW'(k)) && zeroAbove) begin
                blank = 1'b1;
            end
        end
`endif

        segActive = blank ? 7'b0000000 : hexDecode(nibble);
        seg_d     = segActive ^ SEG_OFF;
        an_d      = anOneHot ^ AN_OFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q  <= '0;
            idx_q       <= '0;
            snapshot_q  <= '0;
            frameTick_q <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            prescale_q  <= prescale_d;
            idx_q       <= idx_d;
            snapshot_q  <= snapshot_d;
            frameTick_q <= frameTick_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frameTick_q;

endmodule
